// File: rtl/axi_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_pkg
// Description : Shared constants and FSM state type for the AXI4 read burst
//               master and its burst splitter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_rd_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } RdState_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_splitter
// Description : Combinational size of the next INCR burst:
//               min(remaining, MAX_BURST_BEATS, beats left before 4 KB page end)
// Ports       : addr_lo   - low 12 bits of the current (aligned) byte address
//               remaining - beats still to be requested for the command
//               beats     - beats for the next burst (1..256 when remaining>0)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_splitter
    import axi_rd_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic [11:0]          addr_lo,
    input  logic [LEN_WIDTH-1:0] remaining,
    output logic [8:0]           beats
);

    localparam int                   c_SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0] c_MAX_LW    = LEN_WIDTH'(MAX_BURST_BEATS);
    localparam logic [8:0]           c_MAX_9     = 9'(MAX_BURST_BEATS);

    logic [12:0] w_to_4k;
    logic [8:0]  w_cap;

    always_comb begin
        // 13 bits hold 4096 exactly, so the distance to the page end never wraps
        w_to_4k = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> c_SIZE_LOG2;
        w_cap   = (remaining > c_MAX_LW) ? c_MAX_9 : remaining[8:0];
        beats   = ({4'd0, w_cap} <= w_to_4k) ? w_cap : w_to_4k[8:0];
    end

endmodule
`default_nettype wire

// File: rtl/axi_rd_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_rd_burst_master
// Description : AXI4 read master. Splits one linear read command into INCR
//               bursts (no 4 KB crossing, <= MAX_BURST_BEATS), keeps up to
//               MAX_OUTSTANDING bursts in flight and forwards R data in order
//               onto an AXI-Stream output.
// Ports       : aclk/areset          - clock, synchronous active-high reset
//               cmd_*                - command (addr, beat count) handshake
//               done / err           - completion pulse / sticky RRESP error
//               m_axi_ar* / m_axi_r* - AXI4 read address and data channels
//               m_axis_*             - AXI-Stream read data output
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rd_burst_master
    import axi_rd_pkg::*;
#(
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int LEN_WIDTH       = 20,
    parameter int MAX_BURST_BEATS = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int AXI_ID          = 0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_nbeats,
    output logic                      done,
    output logic                      err,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic [3:0]                m_axi_arqos,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int                        c_SIZE_LOG2  = $clog2(AXI_DATA_WIDTH / 8);
    localparam int                        c_OUT_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_OUT_W-1:0]        c_OUT_MAX    = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] c_ALIGN_MASK = AXI_ADDR_WIDTH'((1 << c_SIZE_LOG2) - 1);

    RdState_t                  r_state;
    logic                      r_cmd_ready;
    logic                      r_done;
    logic                      r_err;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]      r_remaining;
    logic [LEN_WIDTH-1:0]      r_nbeats;
    logic [LEN_WIDTH-1:0]      r_received;
    logic [c_OUT_W-1:0]        r_outstanding;
    logic                      r_arvalid;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]                r_arlen;
    logic [8:0]                r_ar_beats;

    logic [8:0] w_beats;
    logic       w_active;
    logic       w_ar_hs;
    logic       w_r_hs;
    logic       w_last_beat;
    logic       w_unused_rid;

    axi_burst_splitter #(
        .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
        .LEN_WIDTH       (LEN_WIDTH),
        .MAX_BURST_BEATS (MAX_BURST_BEATS)
    ) u_splitter (
        .addr_lo   (r_addr[11:0]),
        .remaining (r_remaining),
        .beats     (w_beats)
    );

    assign w_active     = (r_state == ISSUE) || (r_state == WAIT);
    assign w_ar_hs      = r_arvalid && m_axi_arready;
    assign w_r_hs       = m_axi_rvalid && m_axi_rready;
    // tlast follows the command beat count, not the slave's rlast
    assign w_last_beat  = (r_received + LEN_WIDTH'(1)) == r_nbeats;
    assign w_unused_rid = ^m_axi_rid;

    assign cmd_ready     = r_cmd_ready;
    assign done          = r_done;
    assign err           = r_err;

    assign m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = r_arlen;
    assign m_axi_arsize  = 3'(c_SIZE_LOG2);
    assign m_axi_arburst = AXI_BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arqos   = 4'd0;
    assign m_axi_arvalid = r_arvalid;

    assign m_axis_tdata  = m_axi_rdata;
    assign m_axis_tlast  = w_last_beat;
    assign m_axis_tvalid = m_axi_rvalid && w_active;
    assign m_axi_rready  = m_axis_tready && w_active;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_nbeats      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_ar_beats    <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_r_hs) begin
                r_received <= r_received + LEN_WIDTH'(1);
                if (m_axi_rresp != AXI_RESP_OKAY) begin
                    r_err <= 1'b1;
                end
            end

            case ({w_ar_hs, w_r_hs && m_axi_rlast})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - c_OUT_W'(1);
                default: ;
            endcase

            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_err       <= 1'b0;
                        r_addr      <= cmd_addr & ~c_ALIGN_MASK;
                        r_remaining <= cmd_nbeats;
                        r_nbeats    <= cmd_nbeats;
                        r_received  <= '0;
                        if (cmd_nbeats == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end else begin
                        // First idle cycle after reset raises ready here
                        r_cmd_ready <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (w_ar_hs) begin
                        r_arvalid   <= 1'b0;
                        r_addr      <= r_addr + (AXI_ADDR_WIDTH'(r_ar_beats) << c_SIZE_LOG2);
                        r_remaining <= r_remaining - LEN_WIDTH'(r_ar_beats);
                        if (r_remaining == LEN_WIDTH'(r_ar_beats)) begin
                            r_state <= WAIT;
                        end
                    end else if (!r_arvalid && (r_outstanding < c_OUT_MAX)) begin
                        // Fields are loaded together with arvalid and held until accepted
                        r_arvalid  <= 1'b1;
                        r_araddr   <= r_addr;
                        r_arlen    <= 8'(w_beats - 9'd1);
                        r_ar_beats <= w_beats;
                    end
                end

                WAIT: begin
                    if (w_r_hs && w_last_beat) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end

                DONE: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
